vga_pxl_wr_fifo: RTL
====================

// Module: vga_pxl_wr_fifo
// PURPOSE
//  Write-posting buffer between the MEM stage and the VGA framebuffer.
//  Routed pixel stores (VGA region, resultALU[29:28]==2'b01) are captured on
//  the MEM enable pulse. They drain to the framebuffer write port whenever
//  that port grants access, so the CPU never waits on the display scan.
//  Sits downstream of the top-level memory routing logic and upstream of vga_top's framebuffer.
// PARAMETERS
//  DEPTH   8   entries; power of 2, >=2
//  ADDR_W  17  framebuffer pixel-address width (word index)
//  DATA_W  12  pixel width (RGB444)
// PORTS
//  i_clk        in   1       system clock (clk domain; vga_clk not used here)
//  i_reset      in   1       reset, asynchronous, active-high
//  i_en_MEM     in   1       MEM-stage enable pulse from top_en
//  i_memWrite   in   1       routed VGA store request (ctrlVGA.memWrite)
//  i_pxlAddr    in   32      byte address (resultALU)
//  i_pxlData    in   32      store data (regData2)
//  i_clr_ovf    in   1       synchronous clear of o_overflow
//  i_fb_ready   in   1       framebuffer port accepts a write this cycle
//  o_fb_we      out  1       head entry valid (== !empty)
//  o_fb_addr    out  ADDR_W  head entry address
//  o_fb_data    out  DATA_W  head entry data
//  o_full       out  1       count==DEPTH
//  o_empty      out  1       count==0
//  o_count      out  $clog2(DEPTH)+1  occupancy
//  o_overflow   out  1       sticky: a store was dropped
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - Reset: pointers=0, count=0, o_empty=1, o_full=0, o_fb_we=0, o_overflow=0.
//    o_fb_addr/o_fb_data=0. Array contents are not reset.
//  - push_req = i_en_MEM & i_memWrite. pop = o_fb_we & i_fb_ready.
//  - Entry stored = {i_pxlAddr[ADDR_W+1:2], i_pxlData[DATA_W-1:0]}.
//    Byte offset [1:0] and upper address bits are ignored.
//  - push = push_req & (!o_full | pop).
//    When full, a push succeeds only if a pop occurs in the same cycle.
//  - push_req & !push: entry dropped, o_overflow<=1. Count and pointers unchanged.
//  - o_overflow holds until reset or i_clr_ovf. If a drop and i_clr_ovf occur together, set wins.
//  - Show-ahead output: o_fb_we/o_fb_addr/o_fb_data come combinationally from the
//    array at rd_ptr and are qualified by !empty. Outputs are 0 when empty.
//  - Latency: a push into an empty FIFO appears on o_fb_we the next cycle.
//    There is no same-cycle bypass.
//  - Push and pop in the same cycle: count unchanged, both pointers advance.
//    This applies when full and when count==1. Push into empty plus pop is impossible (o_fb_we=0).
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full/empty derive from count.
//  - Order is strict FIFO. No reads are serviced; VGA-region loads are ignored by this block.
//  - i_fb_ready while empty: no effect.
//  - Async reset mid-drain: the head entry is discarded, and o_fb_we drops immediately (asynchronously).
// TESTING
//  1 Reset, then push A=0x1000_0010,D=0xABC -> next cycle o_fb_we=1,
//    o_fb_addr=0x4, o_fb_data=0xABC, o_count=1.
//  2 i_fb_ready=0, push 8 entries -> o_full=1, count=8. A 9th push sets o_overflow=1,
//    count stays 8, and draining yields entries 1..8 in order.
//  3 Full, push with i_fb_ready=1 in the same cycle -> accepted, count stays 8, no overflow.
//    The newest entry exits 8th.
//  4 Push 20 entries with i_fb_ready toggling every cycle -> all 20 drain in order.
//    Pointers wrap and no overflow occurs.
//  5 i_memWrite=1 with i_en_MEM=0 -> no push. i_en_MEM=1 with i_memWrite=0 -> no push.
//  6 Assert i_reset with count=3 mid-cycle -> o_fb_we=0 and o_count=0 immediately.
//    o_overflow=0. A post-reset push behaves as in test 1.

Source files
------------

// File: rtl/vga_pxl_wr_fifo_if.sv
// Bus bundle for the VGA pixel write-posting FIFO.
// It carries the MEM-side store request, the framebuffer drain port and the status flags.
interface vga_pxl_wr_fifo_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              i_en_MEM;
  logic              i_memWrite;
  logic [31:0]       i_pxlAddr;
  logic [31:0]       i_pxlData;
  logic              i_clr_ovf;
  logic              i_fb_ready;
  logic              o_fb_we;
  logic [ADDR_W-1:0] o_fb_addr;
  logic [DATA_W-1:0] o_fb_data;
  logic              o_full;
  logic              o_empty;
  logic [CNT_W-1:0]  o_count;
  logic              o_overflow;

  modport master (
    output i_en_MEM, i_memWrite, i_pxlAddr, i_pxlData, i_clr_ovf, i_fb_ready,
    input  o_fb_we, o_fb_addr, o_fb_data, o_full, o_empty, o_count, o_overflow
  );

  modport slave (
    input  i_en_MEM, i_memWrite, i_pxlAddr, i_pxlData, i_clr_ovf, i_fb_ready,
    output o_fb_we, o_fb_addr, o_fb_data, o_full, o_empty, o_count, o_overflow
  );
endinterface

// File: rtl/vga_pxl_wr_fifo.sv
// Write-posting FIFO: captures VGA-region pixel stores on the MEM enable pulse.
// It drains them to the framebuffer port in show-ahead fashion whenever that port is ready.
module vga_pxl_wr_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input logic             i_clk,
  input logic             i_reset,
  vga_pxl_wr_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;

  logic             empty;
  logic             full;
  logic             push_req;
  logic             pop;
  logic             push;
  logic [ENT_W-1:0] entry;
  logic [ENT_W-1:0] head;
  logic             unused_bits;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign push_req = bus.i_en_MEM & bus.i_memWrite;
  assign pop      = ~empty & bus.i_fb_ready;
  // A full FIFO still accepts a store when the head leaves in the same cycle
  assign push     = push_req & (~full | pop);

  // Only the word index and the RGB444 bits are kept
  assign entry       = {bus.i_pxlAddr[ADDR_W+1:2], bus.i_pxlData[DATA_W-1:0]};
  assign unused_bits = ^{bus.i_pxlAddr[31:ADDR_W+2], bus.i_pxlAddr[1:0],
                         bus.i_pxlData[31:DATA_W]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // A drop in the same cycle as a clear leaves the flag set
      if (push_req & ~push)
        overflow <= 1'b1;
      else if (bus.i_clr_ovf)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  // Show-ahead head; qualified by count so an async reset blanks it at once
  assign head           = mem[rd_ptr];
  assign bus.o_fb_we    = ~empty;
  assign bus.o_fb_addr  = empty ? '0 : head[ENT_W-1:DATA_W];
  assign bus.o_fb_data  = empty ? '0 : head[DATA_W-1:0];
  assign bus.o_full     = full;
  assign bus.o_empty    = empty;
  assign bus.o_count    = count;
  assign bus.o_overflow = overflow;
endmodule
